// File: rtl/regfile_pkg.sv
// Shared constants and state type for the register-file monitor slice.
package regfile_pkg;

    localparam int REG_WIDTH     = 32;
    localparam int REG_ADDR_W    = 5;
    localparam int REG_ZERO_ADDR = 0;

    typedef enum logic [1:0] {
        IDLE,
        MONITOR,
        HALTED
    } monitor_state_t;

endpackage

// File: rtl/regfile_shadow.sv
// Shadow copy of the register file: per-entry valid bit plus data, one write
// port and two combinational read ports. Address 0 reads as valid zero.
module regfile_shadow
    import regfile_pkg::*;
#(
    parameter int WIDTH  = REG_WIDTH,
    parameter int ADDR_W = REG_ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [WIDTH-1:0]  wdata,
    input  logic [ADDR_W-1:0] raddr1,
    input  logic [ADDR_W-1:0] raddr2,
    output logic              rvalid1,
    output logic [WIDTH-1:0]  rdata1,
    output logic              rvalid2,
    output logic [WIDTH-1:0]  rdata2
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(REG_ZERO_ADDR);

    logic [DEPTH-1:0] valid;
    logic [WIDTH-1:0] mem [DEPTH];

    logic wr_ok;
    assign wr_ok = we && (waddr != ZERO_ADDR);

    // Valid bits: cleared on reset, set by any write to a non-zero address.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid <= '0;
        end else if (wr_ok) begin
            valid[waddr] <= 1'b1;
        end
    end

    // Data array: no reset, contents are don't-care while the entry is invalid.
    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem[waddr] <= wdata;
        end
    end

    // Read ports: address 0 is always valid and reads as zero.
    always_comb begin
        rvalid1 = valid[raddr1];
        rdata1  = mem[raddr1];
        rvalid2 = valid[raddr2];
        rdata2  = mem[raddr2];
        if (raddr1 == ZERO_ADDR) begin
            rvalid1 = 1'b1;
            rdata1  = '0;
        end
        if (raddr2 == ZERO_ADDR) begin
            rvalid2 = 1'b1;
            rdata2  = '0;
        end
    end

endmodule

// File: rtl/regfile_monitor.sv
// Passive scoreboard for a 1W/2R register file: tracks writes in a shadow,
// checks both read ports against it and records errors.
module regfile_monitor
    import regfile_pkg::*;
#(
    parameter int WIDTH         = REG_WIDTH,
    parameter int ADDR_W        = REG_ADDR_W,
    parameter int CNT_W         = 16,
    parameter bit STOP_ON_ERROR = 1'b0
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              CheckEn,
    input  logic              ClearErr,
    input  logic              RegWrite,
    input  logic [ADDR_W-1:0] WriteRegister,
    input  logic [WIDTH-1:0]  WriteData,
    input  logic [ADDR_W-1:0] ReadRegister1,
    input  logic [ADDR_W-1:0] ReadRegister2,
    input  logic [WIDTH-1:0]  ReadData1,
    input  logic [WIDTH-1:0]  ReadData2,
    output logic              ErrorFlag,
    output logic [CNT_W-1:0]  ErrorCount,
    output logic [CNT_W-1:0]  CheckCount,
    output logic              FirstErrPort,
    output logic [ADDR_W-1:0] FirstErrAddr,
    output logic [WIDTH-1:0]  FirstErrExp,
    output logic [WIDTH-1:0]  FirstErrAct,
    output logic              Halted
);

    monitor_state_t state;

    logic             v1, v2;
    logic [WIDTH-1:0] d1, d2;
    logic             chk1, chk2, mis1, mis2;
    logic [1:0]       nchk, nmis;

    function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] c,
                                                 input logic [1:0]       inc);
        logic [CNT_W:0] s;
        s = {1'b0, c} + {{(CNT_W - 1){1'b0}}, inc};
        return s[CNT_W] ? '1 : s[CNT_W-1:0];
    endfunction

    regfile_shadow #(
        .WIDTH  (WIDTH),
        .ADDR_W (ADDR_W)
    ) u_shadow (
        .clk     (Clk),
        .reset   (Reset),
        .we      (RegWrite),
        .waddr   (WriteRegister),
        .wdata   (WriteData),
        .raddr1  (ReadRegister1),
        .raddr2  (ReadRegister2),
        .rvalid1 (v1),
        .rdata1  (d1),
        .rvalid2 (v2),
        .rdata2  (d2)
    );

    // Compare each port against the pre-edge shadow contents.
    always_comb begin
        chk1 = (state == MONITOR) && v1;
        chk2 = (state == MONITOR) && v2;
        mis1 = chk1 && (ReadData1 != d1);
        mis2 = chk2 && (ReadData2 != d2);
        nchk = {1'b0, chk1} + {1'b0, chk2};
        nmis = {1'b0, mis1} + {1'b0, mis2};
    end

    // Control FSM with registered status outputs; reset > clear > update.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state        <= IDLE;
            Halted       <= 1'b0;
            ErrorFlag    <= 1'b0;
            ErrorCount   <= '0;
            CheckCount   <= '0;
            FirstErrPort <= 1'b0;
            FirstErrAddr <= '0;
            FirstErrExp  <= '0;
            FirstErrAct  <= '0;
        end else if (ClearErr) begin
            ErrorFlag    <= 1'b0;
            ErrorCount   <= '0;
            CheckCount   <= '0;
            FirstErrPort <= 1'b0;
            FirstErrAddr <= '0;
            FirstErrExp  <= '0;
            FirstErrAct  <= '0;
            Halted       <= 1'b0;
            if (state == HALTED) begin
                state <= IDLE;
            end else begin
                state <= CheckEn ? MONITOR : IDLE;
            end
        end else begin
            CheckCount <= sat_add(CheckCount, nchk);
            ErrorCount <= sat_add(ErrorCount, nmis);
            if (mis1 || mis2) begin
                ErrorFlag <= 1'b1;
                if (!ErrorFlag) begin
                    FirstErrPort <= !mis1;
                    FirstErrAddr <= mis1 ? ReadRegister1 : ReadRegister2;
                    FirstErrExp  <= mis1 ? d1 : d2;
                    FirstErrAct  <= mis1 ? ReadData1 : ReadData2;
                end
            end
            case (state)
                IDLE: begin
                    if (CheckEn) state <= MONITOR;
                end
                MONITOR: begin
                    if (STOP_ON_ERROR && (mis1 || mis2)) begin
                        state  <= HALTED;
                        Halted <= 1'b1;
                    end else if (!CheckEn) begin
                        state <= IDLE;
                    end
                end
                HALTED: begin
                    state <= HALTED;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_regfile_monitor.sv
// Directed bench for regfile_monitor: two instances (free-running with 16-bit
// counters, stop-on-error with 3-bit counters) share one stimulus stream and
// are compared every cycle against a behavioural scoreboard.
module tb_regfile_monitor;

    logic        Clk = 1'b0;
    logic        Reset, CheckEn, ClearErr, RegWrite;
    logic [4:0]  WriteRegister, ReadRegister1, ReadRegister2;
    logic [31:0] WriteData, ReadData1, ReadData2;

    logic        ef0, fp0, h0, ef1, fp1, h1;
    logic [15:0] ec0, cc0;
    logic [2:0]  ec1, cc1;
    logic [4:0]  fa0, fa1;
    logic [31:0] fe0, fx0, fe1, fx1;

    int errors = 0;
    int checks = 0;

    always #5 Clk = ~Clk;

    regfile_monitor #(
        .WIDTH(32), .ADDR_W(5), .CNT_W(16), .STOP_ON_ERROR(1'b0)
    ) dut0 (
        .Clk(Clk), .Reset(Reset), .CheckEn(CheckEn), .ClearErr(ClearErr),
        .RegWrite(RegWrite), .WriteRegister(WriteRegister), .WriteData(WriteData),
        .ReadRegister1(ReadRegister1), .ReadRegister2(ReadRegister2),
        .ReadData1(ReadData1), .ReadData2(ReadData2),
        .ErrorFlag(ef0), .ErrorCount(ec0), .CheckCount(cc0),
        .FirstErrPort(fp0), .FirstErrAddr(fa0), .FirstErrExp(fe0),
        .FirstErrAct(fx0), .Halted(h0)
    );

    regfile_monitor #(
        .WIDTH(32), .ADDR_W(5), .CNT_W(3), .STOP_ON_ERROR(1'b1)
    ) dut1 (
        .Clk(Clk), .Reset(Reset), .CheckEn(CheckEn), .ClearErr(ClearErr),
        .RegWrite(RegWrite), .WriteRegister(WriteRegister), .WriteData(WriteData),
        .ReadRegister1(ReadRegister1), .ReadRegister2(ReadRegister2),
        .ReadData1(ReadData1), .ReadData2(ReadData2),
        .ErrorFlag(ef1), .ErrorCount(ec1), .CheckCount(cc1),
        .FirstErrPort(fp1), .FirstErrAddr(fa1), .FirstErrExp(fe1),
        .FirstErrAct(fx1), .Halted(h1)
    );

    // ---------------- behavioural scoreboard ----------------
    logic [31:0] shv [32];
    bit          shw [32];
    int unsigned cmax [2] = '{65535, 7};
    int unsigned m_cc [2], m_ec [2];
    bit          m_ef [2], m_fp [2], m_h [2], m_chk [2];
    logic [4:0]  m_fa [2];
    logic [31:0] m_fe [2], m_fx [2];
    bit          armed = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge Clk) begin : model
        logic [31:0] e1, e2;
        bit          k1, k2, act, mm1, mm2;
        int unsigned nc, nm;
        e1 = (ReadRegister1 == 0) ? 32'd0 : shv[ReadRegister1];
        e2 = (ReadRegister2 == 0) ? 32'd0 : shv[ReadRegister2];
        k1 = (ReadRegister1 == 0) || shw[ReadRegister1];
        k2 = (ReadRegister2 == 0) || shw[ReadRegister2];
        for (int k = 0; k < 2; k++) begin
            act = m_chk[k] && !m_h[k];
            mm1 = act && k1 && (ReadData1 !== e1);
            mm2 = act && k2 && (ReadData2 !== e2);
            nc  = (act && k1 ? 1 : 0) + (act && k2 ? 1 : 0);
            nm  = (mm1 ? 1 : 0) + (mm2 ? 1 : 0);
            if (Reset || ClearErr) begin
                m_cc[k] = 0; m_ec[k] = 0; m_ef[k] = 0; m_fp[k] = 0;
                m_fa[k] = 0; m_fe[k] = 0; m_fx[k] = 0;
                if (Reset || m_h[k]) m_chk[k] = 0;
                else                 m_chk[k] = CheckEn;
                m_h[k] = 0;
            end else begin
                m_cc[k] = (m_cc[k] + nc > cmax[k]) ? cmax[k] : m_cc[k] + nc;
                m_ec[k] = (m_ec[k] + nm > cmax[k]) ? cmax[k] : m_ec[k] + nm;
                if (nm > 0) begin
                    if (!m_ef[k]) begin
                        m_fp[k] = !mm1;
                        m_fa[k] = mm1 ? ReadRegister1 : ReadRegister2;
                        m_fe[k] = mm1 ? e1 : e2;
                        m_fx[k] = mm1 ? ReadData1 : ReadData2;
                    end
                    m_ef[k] = 1;
                end
                if (m_h[k]) begin
                    // stays halted until cleared
                end else if (k == 1 && nm > 0) begin
                    m_h[k] = 1; m_chk[k] = 0;
                end else begin
                    m_chk[k] = CheckEn;
                end
            end
        end
        if (Reset) begin
            for (int i = 0; i < 32; i++) shw[i] = 0;
            armed = 1'b1;
        end else if (RegWrite && WriteRegister != 0) begin
            shv[WriteRegister] = WriteData;
            shw[WriteRegister] = 1;
        end
    end

    // Per-cycle comparison of both instances against the scoreboard.
    always @(posedge Clk) begin
        #1;
        if (armed) begin
            chk("ef0", ef0, m_ef[0]); chk("ec0", ec0, m_ec[0]); chk("cc0", cc0, m_cc[0]);
            chk("fp0", fp0, m_fp[0]); chk("fa0", fa0, m_fa[0]); chk("fe0", fe0, m_fe[0]);
            chk("fx0", fx0, m_fx[0]); chk("h0", h0, m_h[0]);
            chk("ef1", ef1, m_ef[1]); chk("ec1", ec1, m_ec[1]); chk("cc1", cc1, m_cc[1]);
            chk("fp1", fp1, m_fp[1]); chk("fa1", fa1, m_fa[1]); chk("fe1", fe1, m_fe[1]);
            chk("fx1", fx1, m_fx[1]); chk("h1", h1, m_h[1]);
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic tick();
        @(posedge Clk);
        #2;
    endtask

    task automatic drive(input bit we, input int wa, input logic [31:0] wd,
                         input int r1, input logic [31:0] d1,
                         input int r2, input logic [31:0] d2);
        RegWrite = we; WriteRegister = 5'(wa); WriteData = wd;
        ReadRegister1 = 5'(r1); ReadData1 = d1;
        ReadRegister2 = 5'(r2); ReadData2 = d2;
        tick();
    endtask

    initial begin
        Reset = 1; CheckEn = 1; ClearErr = 0;
        drive(0, 0, 0, 0, 0, 0, 0);
        chk("reset_ef", ef0, 0); chk("reset_cc", cc0, 0); chk("reset_halt", h1, 0);

        Reset = 0;
        drive(1, 2, 42, 3, 0, 3, 0);
        drive(0, 0, 0, 2, 42, 2, 42);
        chk("r2_cc", cc0, 2); chk("r2_ef", ef0, 0);

        CheckEn = 0;
        for (int i = 1; i < 32; i++) drive(1, i, 32'hFFFF_FFFF, 0, 0, 0, 0);
        CheckEn = 1; ClearErr = 1;
        drive(0, 0, 0, 0, 0, 0, 0);
        ClearErr = 0;
        for (int i = 1; i < 32; i++) drive(0, 0, 0, i, 32'hFFFF_FFFF, 32 - i, 32'hFFFF_FFFF);
        chk("all_cc", cc0, 62); chk("all_ec", ec0, 0); chk("sat_cc1", cc1, 7);

        drive(1, 1, 32'd1955103894, 0, 0, 0, 0);
        drive(0, 0, 0, 1, 3411, 0, 0);
        chk("mm_ef", ef0, 1); chk("mm_ec", ec0, 1); chk("mm_fp", fp0, 0);
        chk("mm_fa", fa0, 1); chk("mm_fe", fe0, 1955103894); chk("mm_fx", fx0, 3411);
        chk("stop_halt", h1, 1);

        ClearErr = 1;
        drive(0, 0, 0, 0, 0, 0, 0);
        chk("clr_halt", h1, 0); chk("clr_ef", ef0, 0);
        ClearErr = 0;
        drive(1, 13, 8193, 0, 0, 0, 0);
        drive(0, 0, 0, 13, 0, 13, 1);
        chk("both_ec", ec0, 2); chk("both_fp", fp0, 0); chk("both_fa", fa0, 13);
        chk("both_fe", fe0, 8193); chk("both_fx", fx0, 0); chk("both_ec1", ec1, 2);

        ClearErr = 1;
        drive(0, 0, 0, 13, 8193, 13, 8193);
        chk("clr2_ec", ec0, 0); chk("clr2_cc", cc0, 0); chk("clr2_fe", fe0, 0);
        ClearErr = 0;
        drive(0, 0, 0, 13, 8193, 13, 8193);
        chk("keep_cc", cc0, 2); chk("keep_ef", ef0, 0);

        drive(1, 0, 3410, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0, 0);
        chk("r0_ok_ef", ef0, 0); chk("r0_ok_cc", cc0, 6);
        drive(0, 0, 0, 0, 3410, 0, 0);
        chk("r0_ef", ef0, 1); chk("r0_fe", fe0, 0); chk("r0_fx", fx0, 3410);
        chk("r0_fa", fa0, 0); chk("r0_halt", h1, 1);
        drive(0, 0, 0, 0, 3410, 13, 5);
        chk("after_ec0", ec0, 3); chk("after_fx0", fx0, 3410);
        chk("halted_ec1", ec1, 1); chk("halted_h1", h1, 1);

        ClearErr = 1;
        drive(0, 0, 0, 0, 0, 0, 0);
        chk("unhalt", h1, 0);
        ClearErr = 0;
        drive(0, 0, 0, 0, 0, 0, 0);

        Reset = 1;
        drive(0, 0, 0, 5, 32'hFFFF_FFFF, 6, 32'hFFFF_FFFF);
        Reset = 0;
        drive(0, 0, 0, 5, 32'hFFFF_FFFF, 6, 32'hFFFF_FFFF);
        drive(0, 0, 0, 5, 32'hFFFF_FFFF, 6, 32'hFFFF_FFFF);
        chk("rst_skip_cc0", cc0, 0); chk("rst_skip_cc1", cc1, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/regfile_monitor.md
Name: regfile_monitor

Overview:
- Passive hardware scoreboard that snoops the register-file port bundle (one write port, two asynchronous read ports) and keeps a shadow copy of all registers.
- Checks every enabled read against the shadow model and reports mismatches through sticky flags, counters and a first-error capture record.
- Sits beside the regfile in the CPU datapath and in benches. It is the observing/responding end of the same interface the stimulus driver exercises.

Parameters:
- WIDTH, 32, data width of each register.
- ADDR_W, 5, register address width; depth = 2**ADDR_W.
- CNT_W, 16, width of the check and error counters.
- STOP_ON_ERROR, 0, 1 = enter HALTED on the first mismatch and stop checking.

Ports:
- Clk  in  1  clock; all state updates on posedge.
- Reset  in  1  synchronous, active-high reset.
- CheckEn  in  1  enable read checking; shadow tracking of writes is always active.
- ClearErr  in  1  synchronous clear of error state/counters; leaves shadow contents intact.
- RegWrite  in  1  snooped write enable.
- WriteRegister  in  ADDR_W  snooped write address.
- WriteData  in  WIDTH  snooped write data.
- ReadRegister1  in  ADDR_W  snooped read address, port 1.
- ReadRegister2  in  ADDR_W  snooped read address, port 2.
- ReadData1  in  WIDTH  snooped read data, port 1.
- ReadData2  in  WIDTH  snooped read data, port 2.
- ErrorFlag  out  1  sticky; set on any mismatch.
- ErrorCount  out  CNT_W  mismatches seen; saturating.
- CheckCount  out  CNT_W  port-checks performed; saturating.
- FirstErrPort  out  1  0 = port 1, 1 = port 2.
- FirstErrAddr  out  ADDR_W  address of the first mismatch.
- FirstErrExp  out  WIDTH  expected value of the first mismatch.
- FirstErrAct  out  WIDTH  observed value of the first mismatch.
- Halted  out  1  high in the HALTED state.

Behaviour:
- Reset: all outputs 0; state IDLE; all shadow valid bits cleared. Shadow data is not cleared; don't-care while invalid. Reset asserted mid-operation has the same effect at the next edge.
- Shadow model:
  - Array of 2**ADDR_W entries, each with a valid bit.
  - Address 0 is hardwired: always valid, expected value 0. Writes to address 0 are ignored.
  - On a posedge with RegWrite=1 and WriteRegister!=0: entry[WriteRegister] <= WriteData and its valid bit <= 1.
- Check timing:
  - Reads are asynchronous, so at each posedge ReadDataN reflects pre-write contents.
  - Each port is compared against the shadow before that edge's shadow update.
  - A write and a read of the same address in one cycle is checked against the OLD value.
- A port check occurs when state=MONITOR and the shadow entry for ReadRegisterN is valid. Reads of never-written registers are skipped and not counted.
- Each port-check increments CheckCount by 1, so up to +2 per cycle.
- A mismatch increments ErrorCount (+2 if both ports mismatch in one cycle) and sets ErrorFlag. Both counters saturate at all-ones.
- First-error capture:
  - Loads only while ErrorFlag=0.
  - If both ports mismatch in the same cycle, port 1 has priority.
  - Results are visible on outputs one cycle after the sampling edge, i.e. they are registered.
- States:
  - IDLE: checking off. Go to MONITOR when CheckEn=1.
  - MONITOR: checking on. Return to IDLE when CheckEn=0. Go to HALTED on a mismatch if STOP_ON_ERROR=1.
  - HALTED: no checks; shadow still tracks writes; Halted=1. Go to IDLE only on ClearErr=1.
- ClearErr: zeroes ErrorFlag, ErrorCount, CheckCount and the FirstErr* outputs next edge. If a mismatch occurs in the same cycle, ClearErr wins and that mismatch is dropped.
- Reset has priority over ClearErr, which has priority over normal update.

Decomposition:
- Shared package regfile_pkg:
  - constants REG_WIDTH=32, REG_ADDR_W=5, REG_ZERO_ADDR=0;
  - state encoding enum monitor_state_t {IDLE, MONITOR, HALTED}.
- One natural sub-module, regfile_shadow: the valid-bit array plus data array, with one write port and two combinational read ports returning {valid, data}. Its address-0 behaviour is hardwired.

Test Plan:
- Reset, CheckEn=1; write 42 to r2; then read r2 on both ports with ReadData=42 -> ErrorFlag=0, CheckCount=2.
- Write 32'hFFFFFFFF to r1..r31 and read each back correctly -> CheckCount=62, ErrorCount=0.
- Write 1955103894 to r1, then drive ReadData1=3411 on a read of r1 -> next cycle ErrorFlag=1, ErrorCount=1, FirstErrPort=0, FirstErrAddr=1, FirstErrExp=1955103894, FirstErrAct=3411.
- Both ports read r13 (shadow 8193) with ReadData1=0, ReadData2=1 -> ErrorCount +2, FirstErrPort=0; then ClearErr -> all error outputs 0, shadow r13 still 8193.
- Write 3410 to r0, then read r0 returning 0 -> no error; read r0 returning 3410 -> error with FirstErrExp=0.
- STOP_ON_ERROR=1: force a mismatch -> Halted=1 and later mismatches are not counted; ClearErr -> IDLE. Reset mid-MONITOR -> reading r5 (previously written) is skipped, CheckCount stays 0.
